// File: rtl/tia_hcount_gen.sv
// Horizontal timing source for the TIA model.
// Divides the colour clock into non-overlapping two-phase clocks and steps a
// 6-bit polynomial horizontal counter once per four colour clocks. It decodes
// the counter into active-low set/reset strobes for the downstream HSYNC and
// HBLANK F1 latches. A line is 57 counter steps (228 colour clocks). rsync
// restarts the line early. hmove_late moves the HBLANK reset strobe later by
// two steps for the current line.
module tia_hcount_gen #(
  parameter int HSYNC_SET_STEP   = 4,
  parameter int HSYNC_RST_STEP   = 8,
  parameter int HBLANK_RST_STEP  = 16,
  parameter int HBLANK_LATE_STEP = 18,
  parameter int LINE_STEPS       = 57
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rsync,
  input  logic       hmove_late,
  output logic       phi1,
  output logic       phi2,
  output logic [5:0] hcount,
  output logic       hsync_s_n,
  output logic       hsync_r_n,
  output logic       hblank_s_n,
  output logic       hblank_r_n,
  output logic       line_start
);

  // Counter value reached after k advances from the all-zero state.
  function automatic logic [5:0] step_code(input int k);
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v = {v[4:0], ~(v[5] ^ v[4])};
    return v;
  endfunction

  localparam logic [5:0] CODE_HS_SET  = step_code(HSYNC_SET_STEP);
  localparam logic [5:0] CODE_HS_RST  = step_code(HSYNC_RST_STEP);
  localparam logic [5:0] CODE_HB_RST  = step_code(HBLANK_RST_STEP);
  localparam logic [5:0] CODE_HB_LATE = step_code(HBLANK_LATE_STEP);
  localparam logic [5:0] CODE_TERM    = step_code(LINE_STEPS - 1);

  logic [1:0] phase;
  logic [5:0] lfsr;
  logic [5:0] lfsr_next;
  logic       pending;
  logic       late;
  logic       late_sel;
  logic       advance;
  logic       restart;

  // The counter moves only on the edge where the phase goes from 2 to 3.
  // A restart occurs on that edge if an rsync is pending or present now, or
  // if the counter is at the last step of the line.
  always_comb begin
    advance   = (phase == 2'd2);
    lfsr_next = {lfsr[4:0], ~(lfsr[5] ^ lfsr[4])};
    restart   = advance & (pending | rsync | (lfsr == CODE_TERM));
  end

  // Phase counter and the registered, glitch-free phase clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= 2'd3;
      phi1  <= 1'b0;
      phi2  <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      phi1  <= (phase == 2'd3);
      phi2  <= (phase == 2'd1);
    end
  end

  // Horizontal counter: advance, or load zero at a wrap or rsync restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= '0;
    end else if (restart) begin
      lfsr <= '0;
    end else if (advance) begin
      lfsr <= lfsr_next;
    end
  end

  // Flags: a pending rsync lasts until the next advance edge. The late flag
  // lasts until the line restarts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      late    <= 1'b0;
    end else begin
      pending <= advance ? 1'b0 : (pending | rsync);
      late    <= restart ? 1'b0 : (late | hmove_late);
    end
  end

  // Capture the late flag on the advance into the normal HBLANK-reset step.
  // This keeps that strobe a full four clocks wide. A flag set after this
  // point has no effect on the current line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      late_sel <= 1'b0;
    end else if (advance && !restart && (lfsr_next == CODE_HB_RST)) begin
      late_sel <= late;
    end
  end

  // One-clock pulse in the cycle after every restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) line_start <= 1'b0;
    else        line_start <= restart;
  end

  // Strobe decode. Each pair is decoded from distinct counter states, so
  // the two strobes of a pair can never be low together.
  always_comb begin
    hcount     = lfsr;
    hblank_s_n = (lfsr != 6'd0);
    hsync_s_n  = (lfsr != CODE_HS_SET);
    hsync_r_n  = (lfsr != CODE_HS_RST);
    hblank_r_n = late_sel ? (lfsr != CODE_HB_LATE) : (lfsr != CODE_HB_RST);
  end

endmodule

// File: tb/tb_tia_hcount_gen.sv
// Bench for tia_hcount_gen: directed line scenarios followed by random
// rsync / hmove_late / reset traffic, compared every cycle against a
// step-index reference model.
module tb_tia_hcount_gen;

  localparam int LINE_STEPS = 57;
  localparam int N_CYCLES   = 4200;
  localparam logic [12:0] RST_VEC = 13'b0_0_0_1_1_0_1_000000;

  logic       clock = 1'b0;
  logic       reset;
  logic       rsync;
  logic       hmove_late;
  logic       phi1, phi2, line_start;
  logic [5:0] hcount;
  logic       hsync_s_n, hsync_r_n, hblank_s_n, hblank_r_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: phase, step index within the line, flags.
  int         m_p, m_step;
  bit         m_pend, m_late, m_l16, m_ls;
  logic [5:0] tbl [0:63];

  // Directed-scenario bookkeeping.
  logic [5:0] seen [0:56];
  int         n_seen = 0;
  int         ls_cnt = 0;

  tia_hcount_gen dut (
    .clock      (clock),
    .reset      (reset),
    .rsync      (rsync),
    .hmove_late (hmove_late),
    .phi1       (phi1),
    .phi2       (phi2),
    .hcount     (hcount),
    .hsync_s_n  (hsync_s_n),
    .hsync_r_n  (hsync_r_n),
    .hblank_s_n (hblank_s_n),
    .hblank_r_n (hblank_r_n),
    .line_start (line_start)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 3; m_step = 0; m_pend = 0; m_late = 0; m_l16 = 0; m_ls = 0;
  endtask

  // One colour-clock edge of the reference model.
  task automatic model_step();
    bit adv;
    adv = (m_p == 2);
    m_p = (m_p + 1) % 4;
    if (adv) begin
      if (m_pend || rsync || m_step == LINE_STEPS - 1) begin
        m_step = 0; m_ls = 1; m_pend = 0; m_late = 0;
      end else begin
        m_step++;
        m_ls = 0;
        if (m_step == 16) m_l16 = m_late;
        m_late = m_late | hmove_late;
      end
    end else begin
      m_ls   = 0;
      m_pend = m_pend | rsync;
      m_late = m_late | hmove_late;
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic hb_r;
    hb_r = m_l16 ? (m_step != 18) : (m_step != 16);
    return {(m_p == 0), (m_p == 2), m_ls, (m_step != 4), (m_step != 8),
            (m_step != 0), hb_r, tbl[m_step]};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {phi1, phi2, line_start, hsync_s_n, hsync_r_n, hblank_s_n, hblank_r_n, hcount};
  endfunction

  // Model follows the DUT clock; a low reset holds it in the reset state.
  always @(posedge clock) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic check_pairs();
    chk("hsync_pair", {15'd0, hsync_s_n | hsync_r_n}, 16'd1);
    chk("hblank_pair", {15'd0, hblank_s_n | hblank_r_n}, 16'd1);
  endtask

  // Per-cycle checks after edge i, plus directed points of the scenarios.
  task automatic check_cycle(input int i);
    int r;
    chk("outs", {3'd0, dut_vec()}, {3'd0, model_vec()});
    check_pairs();
    if (i == 4)   chk("step1_code", {10'd0, hcount}, 16'h0001);
    if (i == 15)  chk("hs_set_before", {15'd0, hsync_s_n}, 16'd1);
    if (i == 16)  chk("hs_set_code", {10'd0, hcount}, 16'h000f);
    if (i == 16)  chk("hs_set_low", {15'd0, hsync_s_n}, 16'd0);
    if (i == 64)  chk("hb_rst_line1", {15'd0, hblank_r_n}, 16'd0);
    if (i == 227) chk("no_ls_early", {15'd0, line_start}, 16'd0);
    if (i == 228) chk("wrap_code", {10'd0, hcount}, 16'd0);
    if (i == 228) chk("wrap_ls", {15'd0, line_start}, 16'd1);
    if (i == 228 + 64) chk("hb_late_not16", {15'd0, hblank_r_n}, 16'd1);
    if (i == 228 + 72) chk("hb_late_18", {15'd0, hblank_r_n}, 16'd0);
    if (i == 456 + 64) chk("hb_revert", {15'd0, hblank_r_n}, 16'd0);
    if (i == 560) chk("rsync_load", {10'd0, hcount}, 16'd0);
    if (i == 560) chk("rsync_ls", {15'd0, line_start}, 16'd1);
    if (i == 575) chk("rsync_hs_before", {15'd0, hsync_s_n}, 16'd1);
    if (i == 576) chk("rsync_hs_16", {15'd0, hsync_s_n}, 16'd0);
    if (i >= 4 && i <= 228 && i % 4 == 0) begin
      seen[n_seen] = hcount;
      n_seen++;
    end
    if (i >= 770 && i <= 800 && line_start) ls_cnt++;
    if (i > 940 && i < 1180) begin
      r = i - 940;
      if (r == 1) chk("rel_phi1", {15'd0, phi1}, 16'd1);
      if (r == 4) chk("rel_step1", {10'd0, hcount}, 16'h0001);
      if (r == 228) chk("rel_wrap_ls", {15'd0, line_start}, 16'd1);
    end
  endtask

  initial begin
    int distinct;
    int rst_hold;
    logic [5:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      tbl[k] = v;
      v = {v[4:0], ~(v[5] ^ v[4])};
    end
    model_reset();
    reset = 1'b0; rsync = 1'b0; hmove_late = 1'b0;
    rst_hold = 0;

    // Clocks while held in reset.
    repeat (3) begin
      @(negedge clock);
      chk("reset_state", {3'd0, dut_vec()}, {3'd0, RST_VEC});
      check_pairs();
    end

    for (int i = 1; i <= N_CYCLES; i++) begin
      logic new_reset;
      if (i < 1180) begin
        rsync      = (i == 557) || (i >= 785 && i <= 787);
        hmove_late = (i == 268);
        new_reset  = !(i >= 938 && i <= 940);
      end else begin
        rsync      = ($urandom_range(0, 39) == 0);
        hmove_late = ($urandom_range(0, 29) == 0);
        if (rst_hold > 0) rst_hold--;
        else if ($urandom_range(0, 799) == 0) rst_hold = 3;
        new_reset  = (rst_hold == 0);
      end
      if (reset && !new_reset) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_async", {3'd0, dut_vec()}, {3'd0, RST_VEC});
        check_pairs();
      end
      reset = new_reset;
      @(posedge clock);
      @(negedge clock);
      check_cycle(i);
    end

    distinct = 0;
    for (int a = 0; a < n_seen; a++) begin
      bit dup;
      dup = 0;
      for (int b = 0; b < a; b++) if (seen[b] == seen[a]) dup = 1;
      if (!dup) distinct++;
    end
    chk("distinct_codes", distinct[15:0], 16'd57);
    chk("coincide_ls_cnt", ls_cnt[15:0], 16'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
